// File: rtl/vc_burst_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : vc_burst_adaptor
//  Description : Turns one cache-line read/write into a multi-beat burst on the
//                physical-memory bus and returns a single line-wide response.
//  Revision    : 1.0  initial release
// ============================================================================
module vc_burst_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  address_i,
    input  logic [LINE_W-1:0]  line_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic [LINE_W-1:0]  line_o,
    output logic               resp_o,
    output logic [ADDR_W-1:0]  address_o,
    output logic [BURST_W-1:0] burst_o,
    output logic               read_o,
    output logic               write_o,
    input  logic [BURST_W-1:0] burst_i,
    input  logic               resp_i
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);

    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [LINE_W-1:0]  r_wline;
    logic               w_last_ack;

    assign w_last_ack = resp_i && (r_cnt == c_last_beat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        read_o       = 1'b0;
        write_o      = 1'b0;
        resp_o       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // write wins if the controller ever raises both
                if (write_i) begin
                    w_state_next = ST_WR;
                end else if (read_i) begin
                    w_state_next = ST_RD;
                end
            end
            ST_RD: begin
                read_o = 1'b1;
                if (w_last_ack) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_WR: begin
                write_o = 1'b1;
                if (w_last_ack) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                resp_o       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_wline   <= '0;
            line_o    <= '0;
            address_o <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (write_i || read_i) begin
                        address_o <= {address_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end
                    if (write_i) begin
                        r_wline <= line_i;
                    end
                end
                ST_RD: begin
                    if (resp_i) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (r_cnt == CNT_W'(b)) begin
                                line_o[b*BURST_W +: BURST_W] <= burst_i;
                            end
                        end
                        // the counter parks on the last beat instead of wrapping
                        if (r_cnt != c_last_beat) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_WR: begin
                    if (resp_i && (r_cnt != c_last_beat)) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        burst_o = '0;
        if (r_state == ST_WR) begin
            for (int b = 0; b < BEATS; b++) begin
                if (r_cnt == CNT_W'(b)) begin
                    burst_o = r_wline[b*BURST_W +: BURST_W];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vc_burst_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vc_burst_adaptor
//  Description : Self-checking bench for vc_burst_adaptor: directed scenarios
//                plus randomized traffic against a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vc_burst_adaptor;

    localparam int LINE_W     = 256;
    localparam int BURST_W    = 64;
    localparam int ADDR_W     = 32;
    localparam int BEATS      = LINE_W / BURST_W;
    localparam int LINE_BYTES = LINE_W / 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [ADDR_W-1:0]  address_i;
    logic [LINE_W-1:0]  line_i;
    logic               read_i;
    logic               write_i;
    logic [LINE_W-1:0]  line_o;
    logic               resp_o;
    logic [ADDR_W-1:0]  address_o;
    logic [BURST_W-1:0] burst_o;
    logic               read_o;
    logic               write_o;
    logic [BURST_W-1:0] burst_i;
    logic               resp_i;

    always #5 clk = ~clk;

    vc_burst_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .address_i(address_i), .line_i(line_i), .read_i(read_i), .write_i(write_i),
        .line_o(line_o), .resp_o(resp_o), .address_o(address_o), .burst_o(burst_o),
        .read_o(read_o), .write_o(write_o), .burst_i(burst_i), .resp_i(resp_i)
    );

    int n_cmp  = 0;
    int n_err  = 0;
    int n_resp = 0;
    logic mem_auto = 1'b0;
    logic [BURST_W-1:0] cap [BEATS];

    function automatic void chk(input string name, input logic [LINE_W-1:0] act,
                                input logic [LINE_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endfunction
    function automatic void chk1(input string name, input logic act, input logic req);
        chk(name, LINE_W'(act), LINE_W'(req));
    endfunction
    function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        chk(name, LINE_W'(act), LINE_W'(req));
    endfunction
    function automatic void chk64(input string name, input logic [63:0] act, input logic [63:0] req);
        chk(name, LINE_W'(act), LINE_W'(req));
    endfunction

    // ---------------- transaction-level reference model ----------------
    logic              m_busy, m_done, m_wr;
    int                m_beats;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_line, m_wline;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_wr    <= 1'b0;
            m_beats <= 0;
            m_addr  <= '0;
            m_line  <= '0;
            m_wline <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_busy) begin
            if (resp_i) begin
                if (!m_wr) m_line[m_beats*BURST_W +: BURST_W] <= burst_i;
                m_beats <= m_beats + 1;
                if (m_beats == BEATS - 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end
        end else if (write_i || read_i) begin
            m_busy  <= 1'b1;
            m_wr    <= write_i;
            m_beats <= 0;
            m_addr  <= (address_i / ADDR_W'(LINE_BYTES)) * ADDR_W'(LINE_BYTES);
            if (write_i) m_wline <= line_i;
        end
    end

    always @(negedge clk) begin
        chk1("m_read_o", read_o, m_busy && !m_wr);
        chk1("m_write_o", write_o, m_busy && m_wr);
        chk1("m_resp_o", resp_o, m_done);
        chk32("m_address_o", address_o, m_addr);
        chk("m_line_o", line_o, m_line);
        if (m_busy && m_wr) chk64("m_burst_o", burst_o, m_wline[m_beats*BURST_W +: BURST_W]);
        if (resp_o === 1'b1) n_resp <= n_resp + 1;
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_auto) begin
            resp_i  = ($urandom_range(0, 2) != 0);
            burst_i = {$urandom, $urandom};
        end
    endtask

    // plays resp_i pattern bits LSB first; beats carry d, gap cycles carry junk
    task automatic feed(input logic [LINE_W-1:0] d, input logic [15:0] pat, input int plen);
        int beat = 0;
        for (int i = 0; i < plen; i++) begin
            resp_i  = pat[i];
            burst_i = pat[i] ? d[beat*BURST_W +: BURST_W] : {$urandom, $urandom};
            @(negedge clk);
            if (pat[i]) begin
                cap[beat] = burst_o;
                beat++;
            end
            tick();
        end
        resp_i = 1'b0;
    endtask

    task automatic finish_txn(input string tag);
        @(negedge clk);
        chk1({tag, "_resp"}, resp_o, 1'b1);
        chk1({tag, "_rw_low"}, read_o | write_o, 1'b0);
        read_i  = 1'b0;
        write_i = 1'b0;
        tick();
        @(negedge clk);
        chk1({tag, "_resp_once"}, resp_o, 1'b0);
    endtask

    localparam logic [BURST_W-1:0] A = 64'hAAAA_0000_AAAA_0001;
    localparam logic [BURST_W-1:0] B = 64'hBBBB_0000_BBBB_0002;
    localparam logic [BURST_W-1:0] C = 64'hCCCC_0000_CCCC_0003;
    localparam logic [BURST_W-1:0] D = 64'hDDDD_0000_DDDD_0004;

    initial begin
        logic [LINE_W-1:0] d1, d3, dw;
        int r0;
        logic got, do_rst;
        int k;

        d1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        d3 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_5A5A_A5A5};
        dw = {D, C, B, A};

        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0;
        line_i = '0; resp_i = 1'b0; burst_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_line_o", line_o, '0);
        chk32("rst_address_o", address_o, 32'h0);
        chk64("rst_burst_o", burst_o, 64'h0);
        chk1("rst_resp_o", resp_o, 1'b0);
        chk1("rst_rw", read_o | write_o, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // back-to-back read
        address_i = 32'h0000_1234; read_i = 1'b1;
        tick();
        feed(d1, 16'hF, 4);
        finish_txn("t1");
        chk32("t1_address_o", address_o, 32'h0000_1220);
        chk("t1_line_o", line_o, d1);

        // gapped write
        address_i = 32'h0000_8040; line_i = dw; write_i = 1'b1;
        tick();
        feed(d1, 16'b1101001, 7);
        finish_txn("t2");
        chk64("t2_beat0", cap[0], A);
        chk64("t2_beat1", cap[1], B);
        chk64("t2_beat2", cap[2], C);
        chk64("t2_beat3", cap[3], D);

        // gapped read
        address_i = 32'h0000_2FFF; read_i = 1'b1;
        tick();
        feed(d3, 16'b1101001, 7);
        finish_txn("t3");
        chk("t3_line_o", line_o, d3);
        chk32("t3_address_o", address_o, 32'h0000_2FE0);

        // reset after two beats of a read, then a clean read
        address_i = 32'h0000_0040; read_i = 1'b1;
        tick();
        feed(d1, 16'b11, 2);
        r0 = n_resp;
        rst = 1'b1; read_i = 1'b0;
        @(negedge clk);
        chk("t4_line_cleared", line_o, '0);
        chk32("t4_address_o", address_o, 32'h0);
        chk1("t4_rw", read_o | write_o, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk32("t4_no_resp", n_resp - r0, 32'd0);
        address_i = 32'h0000_0060; read_i = 1'b1;
        tick();
        feed(d3, 16'hF, 4);
        finish_txn("t4");
        chk("t4_line_o", line_o, d3);

        // both requests high, inputs disturbed mid-burst
        address_i = 32'h0000_3333; line_i = dw; read_i = 1'b1; write_i = 1'b1;
        tick();
        address_i = 32'hFFFF_FFFF; line_i = ~dw;
        feed(d1, 16'hF, 4);
        finish_txn("t5");
        chk64("t5_beat0", cap[0], A);
        chk64("t5_beat3", cap[3], D);
        chk32("t5_address_o", address_o, 32'h0000_3320);
        chk("t5_line_kept", line_o, d3);

        // read then write, request dropped at f+2
        r0 = n_resp;
        address_i = 32'h0000_5000; read_i = 1'b1;
        tick();
        feed(d1, 16'hF, 4);
        @(negedge clk);
        chk1("t6_resp1", resp_o, 1'b1);
        tick();
        read_i = 1'b0; write_i = 1'b1; line_i = dw; address_i = 32'h0000_6000;
        tick();
        feed(d1, 16'hF, 4);
        finish_txn("t6");
        repeat (4) tick();
        @(negedge clk);
        chk32("t6_resp_count", n_resp - r0, 32'd2);
        chk1("t6_idle", read_o | write_o, 1'b0);

        // randomized traffic
        mem_auto = 1'b1;
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 7);
            address_i = $urandom; line_i = rand_line();
            write_i = (k < 3) || (k == 7);
            read_i  = (k >= 3);
            do_rst  = ($urandom_range(0, 9) == 0);
            got = 1'b0;
            for (int c = 0; c < 100 && !got; c++) begin
                tick();
                if (c == 2) begin
                    address_i = $urandom; line_i = rand_line();
                end
                rst = (do_rst && c == 3);
                @(negedge clk);
                if (resp_o === 1'b1) got = 1'b1;
            end
            rst = 1'b0;
            chk1("rnd_txn_done", got, 1'b1);
            tick();
            read_i = 1'b0; write_i = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        mem_auto = 1'b0;
        resp_i = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, actual=timeout required=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire
